alu_issue_stage: RTL and testbench
==================================

# alu_issue_stage

Execute-stage front end of the pipelined 64-bit core: the driving side of the ALU interface. It accepts one decoded instruction per handshake from ID, selects and forwards operands, drives the ALU's two operands and 3-bit control code, and samples the ALU result and zero flag. It registers the result, destination register and branch decision into the EX/MEM register behind a valid/ready handshake, with flush support.

## Interface
- DATA_W, 64, datapath width
- CNT_W, 32, width of the retire counter
- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_valid  in  1  ID has an instruction
- o_ready  out  1  stage can accept
- i_opcode  in  7  RISC-V opcode
- i_funct3  in  3  funct3
- i_funct7_b5  in  1  funct7 bit 5
- i_rs1, i_rs2  in  5 each  source register indices
- i_rs1_data, i_rs2_data  in  DATA_W each  register-file read data
- i_imm  in  DATA_W  sign-extended immediate
- i_rd  in  5  destination index
- i_fwd_mem_en, i_fwd_mem_rd, i_fwd_mem_data  in  1/5/DATA_W  MEM-stage bypass
- i_fwd_wb_en, i_fwd_wb_rd, i_fwd_wb_data  in  1/5/DATA_W  WB-stage bypass
- o_alu_data0, o_alu_data1  out  DATA_W each  ALU operands (combinational)
- o_alu_control  out  3  ALU op: ADD 000, SUB 001, AND 010, OR 011, XOR 100, SLL 101, SRL 110 (arithmetic)
- i_alu_result  in  DATA_W  ALU result
- i_alu_zero  in  1  ALU result == 0
- i_flush  in  1  kill the held entry and the current input
- o_valid  out  1  EX/MEM entry valid
- i_ready  in  1  MEM accepts
- o_result  out  DATA_W  registered result
- o_rd  out  5  registered destination; 0 for branches and stores
- o_br_taken  out  1  registered branch decision
- o_illegal  out  1  registered unsupported-opcode flag
- o_retire_cnt  out  CNT_W  count of entries handed to MEM

## Operation
- Accept when i_valid && o_ready && !i_flush. o_ready = !o_valid || i_ready; forced to 0 while i_rst is high.
- Forwarding per source, rd 0 never forwarded: MEM match (en, rd==rs) wins over WB match; otherwise register data.
- R-type 0110011: data1 = rs2. funct3 000 gives ADD, or SUB when funct7_b5 is set. 111 AND, 110 OR, 100 XOR, 001 SLL, 101 SRL (funct7_b5 ignored). 010 and 011 are illegal.
- I-type 0010011: data1 = imm. Same funct3 mapping, but 000 is always ADD.
- Shifts, both types: data1 = {zeros, value[5:0]}.
- Load 0000011 / store 0100011: ADD, rs1 + imm.
- Branch 1100011: SUB, rs1 - rs2. funct3 000 (BEQ): taken = i_alu_zero. 001 (BNE): taken = !i_alu_zero. Other funct3 values are illegal.
- Any other opcode is illegal: control ADD, result forced to 0, o_illegal=1, o_rd=0.
- o_alu_* are driven from the current inputs every cycle, independent of handshakes.
- On accept, capture result, rd, br_taken and illegal; o_valid=1.
- o_valid && i_ready without a new accept: o_valid=0.
- o_valid && !i_ready: all registered outputs hold stable.
- o_retire_cnt increments on each o_valid && i_ready && !i_flush cycle and wraps modulo 2^CNT_W.

## Timing
- Reset (async assert): o_valid, o_result, o_rd, o_br_taken, o_illegal and o_retire_cnt all go to 0. o_ready=0 while reset is asserted, 1 after.
- Latency: input accepted at edge N appears on o_* after edge N. One instruction per cycle sustained while i_ready=1.
- Simultaneous drain and accept: the new entry replaces the old with no bubble; the counter increments.
- i_flush at edge N: o_valid=0 after N. No accept occurs, and the counter does not increment, even if i_ready=1. Flush has priority over all other events.
- Reset mid-stall discards the held entry.

## Test plan
- ADD: rs1=5, rs2=7, R-type funct3 000 -> o_alu_control=000; one cycle later o_result=12, o_rd=rd, o_valid=1.
- Forwarding: rs1=3, MEM fwd rd=3 data=100, WB fwd rd=3 data=200, rs2 data=1, SUB -> o_alu_data0=100; o_result=99. Same case with rs1=0 -> register data used.
- Shift mask: SLLI with imm=0x41, rs1=1 -> o_alu_data1=1, o_result=2. SRAI of 0x8000_0000_0000_0000 by 4 -> 0xF800_0000_0000_0000.
- Branch: BEQ 9,9 -> o_br_taken=1, o_rd=0. BNE 9,9 -> o_br_taken=0. funct3 010 -> o_illegal=1.
- Backpressure: i_ready=0 for 3 cycles with a held entry -> o_ready=0, outputs stable, counter unchanged. Release -> back-to-back accept, counter +1 per handoff.
- Flush and reset: i_flush together with an accept and i_ready=1 -> o_valid=0, counter unchanged. Async i_rst mid-stall -> all outputs 0 immediately.

Source files
------------

// File: rtl/alu_issue_stage.sv
// Execute-stage front end: operand bypass and decode toward the ALU, with the
// ALU result captured into a valid/ready EX/MEM register that supports flush.
module alu_issue_stage #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [6:0]        i_opcode,
  input  logic [2:0]        i_funct3,
  input  logic              i_funct7_b5,
  input  logic [4:0]        i_rs1,
  input  logic [4:0]        i_rs2,
  input  logic [DATA_W-1:0] i_rs1_data,
  input  logic [DATA_W-1:0] i_rs2_data,
  input  logic [DATA_W-1:0] i_imm,
  input  logic [4:0]        i_rd,
  input  logic              i_fwd_mem_en,
  input  logic [4:0]        i_fwd_mem_rd,
  input  logic [DATA_W-1:0] i_fwd_mem_data,
  input  logic              i_fwd_wb_en,
  input  logic [4:0]        i_fwd_wb_rd,
  input  logic [DATA_W-1:0] i_fwd_wb_data,
  output logic [DATA_W-1:0] o_alu_data0,
  output logic [DATA_W-1:0] o_alu_data1,
  output logic [2:0]        o_alu_control,
  input  logic [DATA_W-1:0] i_alu_result,
  input  logic              i_alu_zero,
  input  logic              i_flush,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_result,
  output logic [4:0]        o_rd,
  output logic              o_br_taken,
  output logic              o_illegal,
  output logic [CNT_W-1:0]  o_retire_cnt
);

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLL = 3'b101,
    ALU_SRL = 3'b110
  } alu_op_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef struct packed {
    alu_op_e op;
    logic    use_imm;
    logic    is_shift;
    logic    is_branch;
    logic    writes_rd;
    logic    illegal;
  } decode_t;

  // MEM is younger than WB, so its value wins; x0 is hard-wired and never bypassed.
  function automatic logic [DATA_W-1:0] bypass(
    input logic [4:0]        rs,
    input logic [DATA_W-1:0] rf_data,
    input logic              mem_en,
    input logic [4:0]        mem_rd,
    input logic [DATA_W-1:0] mem_data,
    input logic              wb_en,
    input logic [4:0]        wb_rd,
    input logic [DATA_W-1:0] wb_data
  );
    logic [DATA_W-1:0] val;
    val = rf_data;
    if (rs != 5'd0) begin
      if (mem_en && (mem_rd == rs))     val = mem_data;
      else if (wb_en && (wb_rd == rs))  val = wb_data;
    end
    return val;
  endfunction

  logic [DATA_W-1:0] rs1_val;
  logic [DATA_W-1:0] rs2_val;
  logic [DATA_W-1:0] operand1;
  decode_t           dec;
  logic              br_taken;
  logic [DATA_W-1:0] result_in;
  logic [4:0]        rd_in;

  logic              valid_q,      valid_d;
  logic [DATA_W-1:0] result_q,     result_d;
  logic [4:0]        rd_q,         rd_d;
  logic              br_taken_q,   br_taken_d;
  logic              illegal_q,    illegal_d;
  logic [CNT_W-1:0]  retire_cnt_q, retire_cnt_d;

  logic accept;
  logic drain;

  assign rs1_val = bypass(i_rs1, i_rs1_data, i_fwd_mem_en, i_fwd_mem_rd, i_fwd_mem_data,
                          i_fwd_wb_en, i_fwd_wb_rd, i_fwd_wb_data);
  assign rs2_val = bypass(i_rs2, i_rs2_data, i_fwd_mem_en, i_fwd_mem_rd, i_fwd_mem_data,
                          i_fwd_wb_en, i_fwd_wb_rd, i_fwd_wb_data);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    dec           = '0;
    dec.op        = ALU_ADD;
    dec.writes_rd = 1'b1;
    unique case (i_opcode)
      OP_R, OP_I: begin
        dec.use_imm = (i_opcode == OP_I);
        unique case (i_funct3)
          3'b000:  dec.op = (i_opcode == OP_R && i_funct7_b5) ? ALU_SUB : ALU_ADD;
          3'b111:  dec.op = ALU_AND;
          3'b110:  dec.op = ALU_OR;
          3'b100:  dec.op = ALU_XOR;
          3'b001: begin
            dec.op       = ALU_SLL;
            dec.is_shift = 1'b1;
          end
          3'b101: begin
            dec.op       = ALU_SRL;
            dec.is_shift = 1'b1;
          end
          default: dec.illegal = 1'b1;
        endcase
      end
      OP_LOAD: begin
        dec.use_imm = 1'b1;
      end
      OP_STORE: begin
        dec.use_imm   = 1'b1;
        dec.writes_rd = 1'b0;
      end
      OP_BRANCH: begin
        dec.op        = ALU_SUB;
        dec.is_branch = 1'b1;
        dec.writes_rd = 1'b0;
        dec.illegal   = (i_funct3[2:1] != 2'b00);
      end
      default: dec.illegal = 1'b1;
    endcase
    if (dec.illegal) dec.writes_rd = 1'b0;
  end

  // Shift amounts only use the low six bits; the rest of the operand is zeroed.
  always_comb begin
    operand1 = dec.use_imm ? i_imm : rs2_val;
    if (dec.is_shift) operand1 = {{(DATA_W-6){1'b0}}, operand1[5:0]};
  end

  assign o_alu_data0   = rs1_val;
  assign o_alu_data1   = operand1;
  assign o_alu_control = dec.op;

  always_comb begin
    br_taken = 1'b0;
    if (dec.is_branch && !dec.illegal) br_taken = i_funct3[0] ? !i_alu_zero : i_alu_zero;
  end

  assign result_in = dec.illegal   ? '0   : i_alu_result;
  assign rd_in     = dec.writes_rd ? i_rd : 5'd0;

  assign o_ready = !i_rst && (!valid_q || i_ready);
  assign accept  = i_valid && o_ready && !i_flush;
  assign drain   = valid_q && i_ready;

  // Flush overrides everything: no capture, no retire count, entry dropped.
  always_comb begin
    valid_d      = valid_q;
    result_d     = result_q;
    rd_d         = rd_q;
    br_taken_d   = br_taken_q;
    illegal_d    = illegal_q;
    retire_cnt_d = retire_cnt_q;
    if (i_flush) begin
      valid_d = 1'b0;
    end else begin
      if (drain) retire_cnt_d = retire_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      if (accept) begin
        valid_d    = 1'b1;
        result_d   = result_in;
        rd_d       = rd_in;
        br_taken_d = br_taken;
        illegal_d  = dec.illegal;
      end else if (drain) begin
        valid_d = 1'b0;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_q      <= 1'b0;
      result_q     <= '0;
      rd_q         <= 5'd0;
      br_taken_q   <= 1'b0;
      illegal_q    <= 1'b0;
      retire_cnt_q <= '0;
    end else begin
      valid_q      <= valid_d;
      result_q     <= result_d;
      rd_q         <= rd_d;
      br_taken_q   <= br_taken_d;
      illegal_q    <= illegal_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign o_valid      = valid_q;
  assign o_result     = result_q;
  assign o_rd         = rd_q;
  assign o_br_taken   = br_taken_q;
  assign o_illegal    = illegal_q;
  assign o_retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: behavioural ALU stub, instruction-level
// reference model compared every negedge, plus directed literal expectations.
module tb_alu_issue_stage;

  localparam int DATA_W = 64;
  localparam int CNT_W  = 4;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  logic              i_clk, i_rst, i_valid, o_ready;
  logic [6:0]        i_opcode;
  logic [2:0]        i_funct3;
  logic              i_funct7_b5;
  logic [4:0]        i_rs1, i_rs2, i_rd;
  logic [DATA_W-1:0] i_rs1_data, i_rs2_data, i_imm;
  logic              i_fwd_mem_en, i_fwd_wb_en;
  logic [4:0]        i_fwd_mem_rd, i_fwd_wb_rd;
  logic [DATA_W-1:0] i_fwd_mem_data, i_fwd_wb_data;
  logic [DATA_W-1:0] o_alu_data0, o_alu_data1, i_alu_result;
  logic [2:0]        o_alu_control;
  logic              i_alu_zero, i_flush, o_valid, i_ready;
  logic [DATA_W-1:0] o_result;
  logic [4:0]        o_rd;
  logic              o_br_taken, o_illegal;
  logic [CNT_W-1:0]  o_retire_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  alu_issue_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_opcode(i_opcode), .i_funct3(i_funct3), .i_funct7_b5(i_funct7_b5),
    .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data),
    .i_imm(i_imm), .i_rd(i_rd),
    .i_fwd_mem_en(i_fwd_mem_en), .i_fwd_mem_rd(i_fwd_mem_rd), .i_fwd_mem_data(i_fwd_mem_data),
    .i_fwd_wb_en(i_fwd_wb_en), .i_fwd_wb_rd(i_fwd_wb_rd), .i_fwd_wb_data(i_fwd_wb_data),
    .o_alu_data0(o_alu_data0), .o_alu_data1(o_alu_data1), .o_alu_control(o_alu_control),
    .i_alu_result(i_alu_result), .i_alu_zero(i_alu_zero), .i_flush(i_flush),
    .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result), .o_rd(o_rd),
    .o_br_taken(o_br_taken), .o_illegal(o_illegal), .o_retire_cnt(o_retire_cnt)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Behavioural ALU driven by the DUT's operand/control outputs.
  always_comb begin
    case (o_alu_control)
      3'b000:  i_alu_result = o_alu_data0 + o_alu_data1;
      3'b001:  i_alu_result = o_alu_data0 - o_alu_data1;
      3'b010:  i_alu_result = o_alu_data0 & o_alu_data1;
      3'b011:  i_alu_result = o_alu_data0 | o_alu_data1;
      3'b100:  i_alu_result = o_alu_data0 ^ o_alu_data1;
      3'b101:  i_alu_result = o_alu_data0 << o_alu_data1[5:0];
      3'b110:  i_alu_result = $signed(o_alu_data0) >>> o_alu_data1[5:0];
      default: i_alu_result = '0;
    endcase
    i_alu_zero = (i_alu_result == '0);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [63:0] d0;
    logic [63:0] d1;
    logic [2:0]  ctrl;
    logic [63:0] res;
    logic [4:0]  rd;
    logic        taken;
    logic        ill;
    logic        ops_known;
    logic        ctrl_known;
  } exp_t;

  function automatic logic [63:0] byp(input logic [4:0] rs, input logic [63:0] rf);
    if (rs == 5'd0) return rf;
    if (i_fwd_mem_en && i_fwd_mem_rd == rs) return i_fwd_mem_data;
    if (i_fwd_wb_en && i_fwd_wb_rd == rs) return i_fwd_wb_data;
    return rf;
  endfunction

  // Instruction semantics computed straight from the current ID inputs.
  function automatic exp_t predict();
    exp_t        e;
    logic [63:0] a, b, rb;
    logic        is_r;
    e = '0;
    e.ops_known  = 1'b1;
    e.ctrl_known = 1'b1;
    a = byp(i_rs1, i_rs1_data);
    rb = byp(i_rs2, i_rs2_data);
    e.d0 = a;
    case (i_opcode)
      OP_R, OP_I: begin
        is_r = (i_opcode == OP_R);
        b = is_r ? rb : i_imm;
        e.rd = i_rd;
        case (i_funct3)
          3'b000: if (is_r && i_funct7_b5) begin e.ctrl = 3'd1; e.res = a - b; end
                  else begin e.ctrl = 3'd0; e.res = a + b; end
          3'b111: begin e.ctrl = 3'd2; e.res = a & b; end
          3'b110: begin e.ctrl = 3'd3; e.res = a | b; end
          3'b100: begin e.ctrl = 3'd4; e.res = a ^ b; end
          3'b001: begin b = b & 64'h3f; e.ctrl = 3'd5; e.res = a << b; end
          3'b101: begin b = b & 64'h3f; e.ctrl = 3'd6; e.res = $signed(a) >>> b; end
          default: e.ill = 1'b1;
        endcase
        e.d1 = b;
      end
      OP_LD, OP_ST: begin
        e.d1 = i_imm;
        e.res = a + i_imm;
        e.rd = (i_opcode == OP_LD) ? i_rd : 5'd0;
      end
      OP_BR: begin
        e.d1 = rb;
        e.ctrl = 3'd1;
        e.res = a - rb;
        if (i_funct3 == 3'b000) e.taken = (a == rb);
        else if (i_funct3 == 3'b001) e.taken = (a != rb);
        else e.ill = 1'b1;
      end
      default: begin
        e.ill = 1'b1;
        e.ctrl = 3'd0;
      end
    endcase
    if (e.ill) begin
      e.res = '0;
      e.rd = 5'd0;
      e.taken = 1'b0;
      e.ops_known = 1'b0;
      e.ctrl_known = !(i_opcode == OP_R || i_opcode == OP_I || i_opcode == OP_BR);
    end
    return e;
  endfunction

  logic             m_valid;
  logic [CNT_W-1:0] m_cnt;
  exp_t             m_e;
  exp_t             ce;

  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      m_valid <= 1'b0;
      m_cnt   <= '0;
      m_e     <= '0;
    end else if (i_flush) begin
      m_valid <= 1'b0;
    end else begin
      if (m_valid && i_ready) m_cnt <= m_cnt + 1'b1;
      if (i_valid && (!m_valid || i_ready)) begin
        m_e     <= predict();
        m_valid <= 1'b1;
      end else if (m_valid && i_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  always @(negedge i_clk) begin
    if (i_rst) begin
      check("rst_valid", o_valid, 0);
      check("rst_ready", o_ready, 0);
      check("rst_cnt", o_retire_cnt, 0);
    end else begin
      ce = predict();
      check("cmp_ready", o_ready, !m_valid || i_ready);
      if (ce.ctrl_known) check("cmp_ctrl", o_alu_control, ce.ctrl);
      if (ce.ops_known) begin
        check("cmp_data0", o_alu_data0, ce.d0);
        check("cmp_data1", o_alu_data1, ce.d1);
      end
      check("cmp_valid", o_valid, m_valid);
      if (m_valid) begin
        check("cmp_result", o_result, m_e.res);
        check("cmp_rd", o_rd, m_e.rd);
        check("cmp_taken", o_br_taken, m_e.taken);
        check("cmp_illegal", o_illegal, m_e.ill);
      end
      check("cmp_cnt", o_retire_cnt, m_cnt);
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic [4:0] rs1, input logic [63:0] d1,
                       input logic [4:0] rs2, input logic [63:0] d2,
                       input logic [63:0] imm, input logic [4:0] rd);
    i_valid = 1'b1;
    i_opcode = op; i_funct3 = f3; i_funct7_b5 = f7;
    i_rs1 = rs1; i_rs1_data = d1; i_rs2 = rs2; i_rs2_data = d2;
    i_imm = imm; i_rd = rd;
  endtask

  task automatic set_fwd(input logic men, input logic [4:0] mrd, input logic [63:0] mdata,
                         input logic wen, input logic [4:0] wrd, input logic [63:0] wdata);
    i_fwd_mem_en = men; i_fwd_mem_rd = mrd; i_fwd_mem_data = mdata;
    i_fwd_wb_en = wen; i_fwd_wb_rd = wrd; i_fwd_wb_data = wdata;
  endtask

  logic [CNT_W-1:0] cnt_snap;

  initial begin
    i_rst = 1'b1; i_ready = 1'b1; i_flush = 1'b0;
    issue(7'd0, 3'd0, 1'b0, 5'd0, 64'd0, 5'd0, 64'd0, 64'd0, 5'd0);
    i_valid = 1'b0;
    set_fwd(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    #2;
    check("reset_valid", o_valid, 0);
    check("reset_ready", o_ready, 0);
    check("reset_result", o_result, 0);
    check("reset_cnt", o_retire_cnt, 0);
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;
    #1 check("ready_after_reset", o_ready, 1);

    // ADD 5 + 7
    issue(OP_R, 3'b000, 1'b0, 5'd1, 64'd5, 5'd2, 64'd7, 64'd0, 5'd10);
    #1 check("add_ctrl", o_alu_control, 3'b000);
    tick();
    check("add_valid", o_valid, 1);
    check("add_result", o_result, 64'd12);
    check("add_rd", o_rd, 5'd10);

    // SUB with MEM over WB forwarding, WB-only forwarding, x0 never forwarded
    set_fwd(1'b1, 5'd3, 64'd100, 1'b1, 5'd3, 64'd200);
    issue(OP_R, 3'b000, 1'b1, 5'd3, 64'd50, 5'd4, 64'd1, 64'd0, 5'd11);
    #1 check("fwd_mem_data0", o_alu_data0, 64'd100);
    tick();
    check("fwd_mem_result", o_result, 64'd99);
    set_fwd(1'b0, 5'd3, 64'd100, 1'b1, 5'd3, 64'd200);
    tick();
    check("fwd_wb_result", o_result, 64'd199);
    set_fwd(1'b1, 5'd0, 64'd100, 1'b1, 5'd0, 64'd200);
    issue(OP_R, 3'b000, 1'b1, 5'd0, 64'd50, 5'd4, 64'd1, 64'd0, 5'd13);
    #1 check("fwd_x0_data0", o_alu_data0, 64'd50);
    tick();
    check("fwd_x0_result", o_result, 64'd49);
    set_fwd(1'b1, 5'd4, 64'd9, 1'b0, 5'd0, 64'd0);
    issue(OP_R, 3'b000, 1'b0, 5'd1, 64'd1, 5'd4, 64'd1, 64'd0, 5'd13);
    tick();
    check("fwd_rs2_result", o_result, 64'd10);
    set_fwd(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);

    // Shifts and logic ops
    issue(OP_I, 3'b001, 1'b0, 5'd1, 64'd1, 5'd0, 64'd0, 64'h41, 5'd14);
    #1 check("slli_data1", o_alu_data1, 64'd1);
    tick();
    check("slli_result", o_result, 64'd2);
    issue(OP_I, 3'b101, 1'b1, 5'd1, 64'h8000_0000_0000_0000, 5'd0, 64'd0, 64'h404, 5'd15);
    tick();
    check("srai_result", o_result, 64'hF800_0000_0000_0000);
    issue(OP_R, 3'b101, 1'b0, 5'd1, 64'hF0, 5'd2, 64'h44, 64'd0, 5'd16);
    tick();
    check("srl_r_result", o_result, 64'h0F);
    issue(OP_R, 3'b100, 1'b0, 5'd1, 64'hF0, 5'd2, 64'hFF, 64'd0, 5'd17);
    tick();
    check("xor_result", o_result, 64'h0F);
    issue(OP_I, 3'b111, 1'b0, 5'd1, 64'hFF, 5'd0, 64'd0, 64'h3C, 5'd18);
    tick();
    check("andi_result", o_result, 64'h3C);
    issue(OP_I, 3'b000, 1'b1, 5'd1, 64'd10, 5'd0, 64'd0, 64'd3, 5'd18);
    tick();
    check("addi_f7_result", o_result, 64'd13);
    issue(OP_R, 3'b110, 1'b0, 5'd1, 64'h0F, 5'd2, 64'hF0, 64'd0, 5'd19);
    tick();
    check("or_result", o_result, 64'hFF);

    // Load / store
    issue(OP_LD, 3'b011, 1'b0, 5'd1, 64'd1000, 5'd0, 64'd0, -64'sd8, 5'd6);
    tick();
    check("load_result", o_result, 64'd992);
    check("load_rd", o_rd, 5'd6);
    issue(OP_ST, 3'b011, 1'b0, 5'd1, 64'd1000, 5'd2, 64'd5, 64'd16, 5'd6);
    tick();
    check("store_result", o_result, 64'd1016);
    check("store_rd", o_rd, 5'd0);

    // Branches and illegal encodings
    issue(OP_BR, 3'b000, 1'b0, 5'd1, 64'd9, 5'd2, 64'd9, 64'd0, 5'd5);
    #1 check("beq_ctrl", o_alu_control, 3'b001);
    tick();
    check("beq_taken", o_br_taken, 1);
    check("beq_rd", o_rd, 5'd0);
    issue(OP_BR, 3'b001, 1'b0, 5'd1, 64'd9, 5'd2, 64'd9, 64'd0, 5'd5);
    tick();
    check("bne_taken", o_br_taken, 0);
    issue(OP_BR, 3'b001, 1'b0, 5'd1, 64'd9, 5'd2, 64'd8, 64'd0, 5'd5);
    tick();
    check("bne_ne_taken", o_br_taken, 1);
    issue(OP_BR, 3'b010, 1'b0, 5'd1, 64'd9, 5'd2, 64'd9, 64'd0, 5'd5);
    tick();
    check("br_f3_illegal", o_illegal, 1);
    issue(7'h7F, 3'b000, 1'b0, 5'd1, 64'd3, 5'd2, 64'd4, 64'd0, 5'd7);
    #1 check("illop_ctrl", o_alu_control, 3'b000);
    tick();
    check("illop_flag", o_illegal, 1);
    check("illop_result", o_result, 64'd0);
    check("illop_rd", o_rd, 5'd0);
    issue(OP_R, 3'b010, 1'b0, 5'd1, 64'd3, 5'd2, 64'd4, 64'd0, 5'd7);
    tick();
    check("r_f3_illegal", o_illegal, 1);

    // Backpressure: hold for three cycles, then back-to-back handoffs
    issue(OP_R, 3'b000, 1'b0, 5'd1, 64'd1, 5'd2, 64'd2, 64'd0, 5'd7);
    tick();
    cnt_snap = m_cnt;
    i_ready = 1'b0;
    issue(OP_R, 3'b000, 1'b0, 5'd1, 64'd10, 5'd2, 64'd20, 64'd0, 5'd8);
    #1 check("stall_ready", o_ready, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall_result", o_result, 64'd3);
      check("stall_valid", o_valid, 1);
      check("stall_cnt", o_retire_cnt, cnt_snap);
    end
    i_ready = 1'b1;
    #1 check("release_ready", o_ready, 1);
    tick();
    check("release_result", o_result, 64'd30);
    check("release_cnt", o_retire_cnt, cnt_snap + 4'd1);
    issue(OP_R, 3'b000, 1'b0, 5'd1, 64'd100, 5'd2, 64'd1, 64'd0, 5'd9);
    tick();
    check("b2b_result", o_result, 64'd101);
    check("b2b_cnt", o_retire_cnt, cnt_snap + 4'd2);

    // Flush with a held entry, a new input and i_ready=1
    issue(OP_R, 3'b000, 1'b0, 5'd1, 64'd5, 5'd2, 64'd5, 64'd0, 5'd9);
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    i_valid = 1'b0;
    check("flush_valid", o_valid, 0);
    check("flush_cnt", o_retire_cnt, cnt_snap + 4'd2);

    // Async reset while stalled
    issue(OP_R, 3'b000, 1'b0, 5'd1, 64'd2, 5'd2, 64'd2, 64'd0, 5'd3);
    tick();
    i_ready = 1'b0;
    i_valid = 1'b0;
    tick();
    #2 i_rst = 1'b1;
    #1;
    check("async_rst_valid", o_valid, 0);
    check("async_rst_result", o_result, 64'd0);
    check("async_rst_rd", o_rd, 5'd0);
    check("async_rst_cnt", o_retire_cnt, 0);
    check("async_rst_ready", o_ready, 0);
    check("async_rst_illegal", o_illegal, 0);
    check("async_rst_taken", o_br_taken, 0);
    @(posedge i_clk);
    #1 i_rst = 1'b0;
    i_ready = 1'b1;

    // Sixteen back-to-back handoffs wrap the 4-bit retire counter
    for (int k = 0; k < 16; k++) begin
      issue(OP_I, 3'b000, 1'b0, 5'd1, 64'(k), 5'd0, 64'd0, 64'd1, 5'(k + 1));
      tick();
    end
    check("burst_cnt", o_retire_cnt, 4'd15);
    check("burst_last_result", o_result, 64'd16);
    i_valid = 1'b0;
    tick();
    check("wrap_cnt", o_retire_cnt, 4'd0);
    check("wrap_valid", o_valid, 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
